// File: rtl/uart_word_loader.sv
// uart_word_loader: parses framed UART packets (sync, 16-bit word count,
// payload, XOR checksum) and writes the assembled DATA_W-bit words to an
// instruction RAM write port at consecutive addresses starting from 0.
module uart_word_loader #(
  parameter int         DATA_W      = 16,
  parameter int         ADDR_W      = 8,
  parameter int         BYTE_ORDER  = 0,
  parameter logic [7:0] SYNC_BYTE   = 8'hA5,
  parameter int         TIMEOUT_CYC = 10_000_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_done,
  input  logic [7:0]        rx_data,
  output logic              ram_enable,
  output logic [ADDR_W-1:0] ram_wa,
  output logic [DATA_W-1:0] ram_din,
  output logic              busy,
  output logic              done,
  output logic              err_cksum,
  output logic              err_len,
  output logic              err_timeout,
  output logic [ADDR_W:0]   word_cnt
);

  localparam int BPW   = DATA_W / 8;
  localparam int IDX_W = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BPW - 1);
  localparam logic [TO_W-1:0]  TO_LIMIT = TO_W'(TIMEOUT_CYC);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CNT_HI,
    S_CNT_LO,
    S_DATA,
    S_CKSUM
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [7:0]        r_cnt_hi;
  logic [15:0]       r_n;
  logic [IDX_W-1:0]  r_byte_idx;
  logic [DATA_W-1:0] r_asm;
  logic [7:0]        r_cksum;
  logic [TO_W-1:0]   r_to_cnt;

  logic [15:0]       w_n;
  logic              w_len_bad;
  logic              w_word_last;
  logic              w_last_word;
  logic              w_timeout;
  logic [DATA_W-1:0] w_asm;

  // The address of the next write is simply the low bits of the word count;
  // the length check guarantees it never wraps inside one packet.
  assign w_n         = {r_cnt_hi, rx_data};
  assign w_len_bad   = ({16'd0, w_n} > (32'd1 << ADDR_W));
  assign w_word_last = (r_byte_idx == LAST_IDX);
  assign w_last_word = ((32'(word_cnt) + 32'd1) == {16'd0, r_n});
  // A byte arriving in the expiry cycle wins over the timeout.
  assign w_timeout   = (r_state != S_IDLE) && !rx_done && (r_to_cnt == TO_LIMIT);
  assign busy        = (r_state != S_IDLE);

  // Word assembler: shift the new byte in from the side selected by BYTE_ORDER.
  always_comb begin
    if (BYTE_ORDER == 0) w_asm = (r_asm << 8) | DATA_W'(rx_data);
    else                 w_asm = (r_asm >> 8) | (DATA_W'(rx_data) << (DATA_W - 8));
  end

  // State register.
  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // values from before the edge; blocking here would create ordering races.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // Next-state decode driven by byte strobes and the inter-byte timeout.
  // NOTE: the default assignment first keeps this purely combinational; a
  // path that left w_state_next unassigned would infer a latch.
  always_comb begin
    w_state_next = r_state;
    if (w_timeout) begin
      w_state_next = S_IDLE;
    end else if (rx_done) begin
      case (r_state)
        S_IDLE:   if (rx_data == SYNC_BYTE) w_state_next = S_CNT_HI;
        S_CNT_HI: w_state_next = S_CNT_LO;
        S_CNT_LO: begin
          if (w_len_bad)      w_state_next = S_IDLE;
          else if (w_n == '0) w_state_next = S_CKSUM;
          else                w_state_next = S_DATA;
        end
        S_DATA:   if (w_word_last && w_last_word) w_state_next = S_CKSUM;
        S_CKSUM:  w_state_next = S_IDLE;
        default:  w_state_next = S_IDLE;
      endcase
    end
  end

  // Inter-byte timeout counter: cleared on every byte and whenever idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                  r_to_cnt <= '0;
    else if (rx_done || w_state_next == S_IDLE) r_to_cnt <= '0;
    else                                        r_to_cnt <= r_to_cnt + 1'b1;
  end

  // Packet datapath: count latch, checksum, word assembly, RAM writes, flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ram_enable  <= 1'b0;
      ram_wa      <= '0;
      ram_din     <= '0;
      done        <= 1'b0;
      err_cksum   <= 1'b0;
      err_len     <= 1'b0;
      err_timeout <= 1'b0;
      word_cnt    <= '0;
      r_cnt_hi    <= '0;
      r_n         <= '0;
      r_byte_idx  <= '0;
      r_asm       <= '0;
      r_cksum     <= '0;
    end else begin
      ram_enable <= 1'b0;
      if (w_timeout) begin
        err_timeout <= 1'b1;
      end else if (rx_done) begin
        case (r_state)
          S_IDLE: begin
            if (rx_data == SYNC_BYTE) begin
              done        <= 1'b0;
              err_cksum   <= 1'b0;
              err_len     <= 1'b0;
              err_timeout <= 1'b0;
              word_cnt    <= '0;
              r_byte_idx  <= '0;
              r_cksum     <= '0;
            end
          end
          S_CNT_HI: r_cnt_hi <= rx_data;
          S_CNT_LO: begin
            r_n <= w_n;
            if (w_len_bad) err_len <= 1'b1;
          end
          S_DATA: begin
            r_cksum <= r_cksum ^ rx_data;
            r_asm   <= w_asm;
            if (w_word_last) begin
              ram_enable <= 1'b1;
              ram_wa     <= word_cnt[ADDR_W-1:0];
              ram_din    <= w_asm;
              word_cnt   <= word_cnt + 1'b1;
              r_byte_idx <= '0;
            end else begin
              r_byte_idx <= r_byte_idx + 1'b1;
            end
          end
          S_CKSUM: begin
            if (rx_data == r_cksum) done      <= 1'b1;
            else                    err_cksum <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_word_loader.sv
// Bench for uart_word_loader: three instances with different widths and byte
// orders, driven by directed and random packets, checked against a
// packet-level reference model (expected writes, timing and flags).
`timescale 1ns/1ps
module tb_uart_word_loader;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  typedef struct {
    logic        busy, done, ec, el, et;
    logic [31:0] wc;
  } st_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       rxd[3];
  logic [7:0] rxb[3];

  // instance 0: 16-bit, MSB first, 256 words
  logic en0, busy0, done0, ec0, el0, et0;
  logic [7:0]  wa0;
  logic [15:0] din0;
  logic [8:0]  wc0;
  // instance 1: 16-bit, LSB first, 8 words
  logic en1, busy1, done1, ec1, el1, et1;
  logic [2:0]  wa1;
  logic [15:0] din1;
  logic [3:0]  wc1;
  // instance 2: 32-bit, MSB first, 16 words
  logic en2, busy2, done2, ec2, el2, et2;
  logic [3:0]  wa2;
  logic [31:0] din2;
  logic [4:0]  wc2;

  uart_word_loader #(.DATA_W(16), .ADDR_W(8), .BYTE_ORDER(0), .TIMEOUT_CYC(100)) u_d0 (
    .clk(clk), .reset(rst), .rx_done(rxd[0]), .rx_data(rxb[0]),
    .ram_enable(en0), .ram_wa(wa0), .ram_din(din0), .busy(busy0), .done(done0),
    .err_cksum(ec0), .err_len(el0), .err_timeout(et0), .word_cnt(wc0));

  uart_word_loader #(.DATA_W(16), .ADDR_W(3), .BYTE_ORDER(1), .TIMEOUT_CYC(100)) u_d1 (
    .clk(clk), .reset(rst), .rx_done(rxd[1]), .rx_data(rxb[1]),
    .ram_enable(en1), .ram_wa(wa1), .ram_din(din1), .busy(busy1), .done(done1),
    .err_cksum(ec1), .err_len(el1), .err_timeout(et1), .word_cnt(wc1));

  uart_word_loader #(.DATA_W(32), .ADDR_W(4), .BYTE_ORDER(0), .TIMEOUT_CYC(100)) u_d2 (
    .clk(clk), .reset(rst), .rx_done(rxd[2]), .rx_data(rxb[2]),
    .ram_enable(en2), .ram_wa(wa2), .ram_din(din2), .busy(busy2), .done(done2),
    .err_cksum(ec2), .err_len(el2), .err_timeout(et2), .word_cnt(wc2));

  wr_t wq0[$], wq1[$], wq2[$];
  always @(negedge clk) if (en0 === 1'b1) wq0.push_back('{addr: 32'(wa0), data: 32'(din0), cyc: cyc});
  always @(negedge clk) if (en1 === 1'b1) wq1.push_back('{addr: 32'(wa1), data: 32'(din1), cyc: cyc});
  always @(negedge clk) if (en2 === 1'b1) wq2.push_back('{addr: 32'(wa2), data: 32'(din2), cyc: cyc});

  int total = 0;
  int bad   = 0;

  logic [7:0] pkt[$];
  int         bc[$];
  wr_t        exp_q[$];
  logic       exp_done, exp_ck, exp_len;
  int         exp_wc;

  function automatic int bpw_of(int i); return (i == 2) ? 4 : 2; endfunction
  function automatic int aw_of(int i);  return (i == 0) ? 8 : (i == 1) ? 3 : 4; endfunction
  function automatic int bo_of(int i);  return (i == 1) ? 1 : 0; endfunction

  function automatic int wq_size(int i);
    case (i)
      0:       return wq0.size();
      1:       return wq1.size();
      default: return wq2.size();
    endcase
  endfunction

  function automatic wr_t pop_wr(int i);
    case (i)
      0:       return wq0.pop_front();
      1:       return wq1.pop_front();
      default: return wq2.pop_front();
    endcase
  endfunction

  function automatic st_t get_st(int i);
    st_t s;
    case (i)
      0:       s = '{busy: busy0, done: done0, ec: ec0, el: el0, et: et0, wc: 32'(wc0)};
      1:       s = '{busy: busy1, done: done1, ec: ec1, el: el1, et: et1, wc: 32'(wc1)};
      default: s = '{busy: busy2, done: done2, ec: ec2, el: el2, et: et2, wc: 32'(wc2)};
    endcase
    return s;
  endfunction

  // Drive one byte strobe; returns the cycle number at which results of
  // that byte are visible (the negedge right after it was sampled).
  task automatic send_byte(input int i, input logic [7:0] b, output int c);
    rxd[i] = 1'b1;
    rxb[i] = b;
    @(negedge clk);
    c = cyc;
    rxd[i] = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reference model: packet-level interpretation of the byte list in pkt
  // and the byte arrival cycles in bc.
  task automatic model(input int i);
    int bpw, n, cap;
    logic [7:0]  ck, b;
    logic [31:0] w;
    bpw = bpw_of(i);
    cap = 1 << aw_of(i);
    n   = {16'd0, pkt[1], pkt[2]};
    exp_q.delete();
    exp_done = 1'b0; exp_ck = 1'b0; exp_len = 1'b0; exp_wc = 0;
    if (n > cap) begin
      exp_len = 1'b1;
      return;
    end
    ck = 8'h00;
    for (int k = 0; k < n; k++) begin
      w = 32'h0;
      for (int j = 0; j < bpw; j++) begin
        b  = pkt[3 + k*bpw + j];
        ck = ck ^ b;
        if (bo_of(i) == 0) w = w | (32'(b) << (8 * (bpw - 1 - j)));
        else               w = w | (32'(b) << (8 * j));
      end
      exp_q.push_back('{addr: 32'(k), data: w, cyc: bc[3 + k*bpw + bpw - 1]});
    end
    exp_done = (pkt[3 + n*bpw] == ck);
    exp_ck   = !exp_done;
    exp_wc   = n;
  endtask

  task automatic build_pkt(input int i, input int n, input bit bad_ck);
    logic [7:0] ck, b;
    ck = 8'h00;
    pkt.delete();
    pkt.push_back(8'hA5);
    pkt.push_back(8'(n >> 8));
    pkt.push_back(8'(n));
    if (n > (1 << aw_of(i))) return;
    for (int k = 0; k < n * bpw_of(i); k++) begin
      b  = 8'($urandom);
      ck = ck ^ b;
      pkt.push_back(b);
    end
    if (bad_ck) ck = ck ^ 8'(1 << $urandom_range(7, 0));
    pkt.push_back(ck);
  endtask

  task automatic run_pkt(input int i, input int gap_max);
    int c;
    bc.delete();
    foreach (pkt[k]) begin
      send_byte(i, pkt[k], c);
      bc.push_back(c);
      if (gap_max > 0 && k != pkt.size() - 1) idle($urandom_range(gap_max, 0));
    end
    model(i);
  endtask

  task automatic test_reset;
    idle(3);
    total++;
    if ({en0, wa0, din0, busy0, done0, ec0, el0, et0, wc0} !== '0) begin
      bad++; $display("FAIL reset_d0: got %h want 0", {en0, wa0, din0, busy0, done0, ec0, el0, et0, wc0});
    end
    total++;
    if ({en1, wa1, din1, busy1, done1, ec1, el1, et1, wc1} !== '0) begin
      bad++; $display("FAIL reset_d1: got %h want 0", {en1, wa1, din1, busy1, done1, ec1, el1, et1, wc1});
    end
    total++;
    if ({en2, wa2, din2, busy2, done2, ec2, el2, et2, wc2} !== '0) begin
      bad++; $display("FAIL reset_d2: got %h want 0", {en2, wa2, din2, busy2, done2, ec2, el2, et2, wc2});
    end
    rst = 1'b0;
    idle(2);
  endtask

  task automatic test_directed;
    int i, c;
    st_t s;
    wr_t g, e;
    for (int t = 0; t < 3; t++) begin
      case (t)
        0: begin i = 0; pkt = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40}; end
        1: begin i = 1; pkt = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h41}; end
        default: begin
          i = 0;
          send_byte(0, 8'h00, c);
          send_byte(0, 8'hFF, c);
          total++;
          if (busy0 !== 1'b0) begin bad++; $display("FAIL junk_busy: got %b want 0", busy0); end
          pkt = '{8'hA5, 8'h00, 8'h00, 8'h00};
        end
      endcase
      run_pkt(i, 0);
      #1;
      s = get_st(i);
      total++;
      if ({s.busy, s.done, s.ec, s.el, s.et} !== {1'b0, exp_done, exp_ck, exp_len, 1'b0}) begin
        bad++; $display("FAIL dir%0d_flags: got %b want %b", t, {s.busy, s.done, s.ec, s.el, s.et}, {1'b0, exp_done, exp_ck, exp_len, 1'b0});
      end
      total++;
      if (s.wc !== 32'(exp_wc)) begin bad++; $display("FAIL dir%0d_wc: got %0d want %0d", t, s.wc, exp_wc); end
      total++;
      if (wq_size(i) != exp_q.size()) begin bad++; $display("FAIL dir%0d_nwr: got %0d want %0d", t, wq_size(i), exp_q.size()); end
      while (exp_q.size() > 0 && wq_size(i) > 0) begin
        g = pop_wr(i); e = exp_q.pop_front();
        total++;
        if (g.addr !== e.addr || g.data !== e.data || g.cyc != e.cyc) begin
          bad++; $display("FAIL dir%0d_wr: got a=%0h d=%h c=%0d want a=%0h d=%h c=%0d", t, g.addr, g.data, g.cyc, e.addr, e.data, e.cyc);
        end
      end
      while (wq_size(i) > 0) g = pop_wr(i);
    end
  endtask

  // Length limit: overlong count rejected, next packet clears the error,
  // and a packet of exactly full capacity is accepted.
  task automatic test_length;
    int i;
    st_t s;
    wr_t g, e;
    for (int t = 0; t < 4; t++) begin
      case (t)
        0: begin i = 0; pkt = '{8'hA5, 8'h01, 8'h01}; end
        1: begin i = 0; build_pkt(0, 3, 1'b0); end
        2: begin i = 1; build_pkt(1, 9, 1'b0); end
        default: begin i = 1; build_pkt(1, 8, 1'b0); end
      endcase
      run_pkt(i, 2);
      #1;
      s = get_st(i);
      total++;
      if ({s.busy, s.done, s.ec, s.el, s.et} !== {1'b0, exp_done, exp_ck, exp_len, 1'b0}) begin
        bad++; $display("FAIL len%0d_flags: got %b want %b", t, {s.busy, s.done, s.ec, s.el, s.et}, {1'b0, exp_done, exp_ck, exp_len, 1'b0});
      end
      total++;
      if (s.wc !== 32'(exp_wc)) begin bad++; $display("FAIL len%0d_wc: got %0d want %0d", t, s.wc, exp_wc); end
      total++;
      if (wq_size(i) != exp_q.size()) begin bad++; $display("FAIL len%0d_nwr: got %0d want %0d", t, wq_size(i), exp_q.size()); end
      while (exp_q.size() > 0 && wq_size(i) > 0) begin
        g = pop_wr(i); e = exp_q.pop_front();
        total++;
        if (g.addr !== e.addr || g.data !== e.data || g.cyc != e.cyc) begin
          bad++; $display("FAIL len%0d_wr: got a=%0h d=%h c=%0d want a=%0h d=%h c=%0d", t, g.addr, g.data, g.cyc, e.addr, e.data, e.cyc);
        end
      end
      while (wq_size(i) > 0) g = pop_wr(i);
    end
  endtask

  // Back-to-back bytes on the 32-bit instance (4 words) followed by a
  // series of random packets on random instances with random gaps.
  task automatic test_back_to_back;
    int i, n;
    st_t s;
    wr_t g, e;
    for (int t = 0; t < 13; t++) begin
      if (t == 0) begin
        i = 2;
        build_pkt(2, 4, 1'b0);
        run_pkt(2, 0);
      end else begin
        i = $urandom_range(2, 0);
        n = $urandom_range((i == 1) ? 8 : 6, 0);
        build_pkt(i, n, ($urandom_range(3, 0) == 0));
        run_pkt(i, 3);
      end
      #1;
      s = get_st(i);
      total++;
      if ({s.busy, s.done, s.ec, s.el, s.et} !== {1'b0, exp_done, exp_ck, exp_len, 1'b0}) begin
        bad++; $display("FAIL pkt%0d_flags: got %b want %b", t, {s.busy, s.done, s.ec, s.el, s.et}, {1'b0, exp_done, exp_ck, exp_len, 1'b0});
      end
      total++;
      if (s.wc !== 32'(exp_wc)) begin bad++; $display("FAIL pkt%0d_wc: got %0d want %0d", t, s.wc, exp_wc); end
      total++;
      if (wq_size(i) != exp_q.size()) begin bad++; $display("FAIL pkt%0d_nwr: got %0d want %0d", t, wq_size(i), exp_q.size()); end
      while (exp_q.size() > 0 && wq_size(i) > 0) begin
        g = pop_wr(i); e = exp_q.pop_front();
        total++;
        if (g.addr !== e.addr || g.data !== e.data || g.cyc != e.cyc) begin
          bad++; $display("FAIL pkt%0d_wr: got a=%0h d=%h c=%0d want a=%0h d=%h c=%0d", t, g.addr, g.data, g.cyc, e.addr, e.data, e.cyc);
        end
      end
      while (wq_size(i) > 0) g = pop_wr(i);
    end
  endtask

  task automatic test_timeout;
    int c;
    st_t s;
    wr_t g, e;
    pkt = '{8'hA5, 8'h00, 8'h01, 8'h12};
    foreach (pkt[k]) send_byte(0, pkt[k], c);
    idle(100);
    s = get_st(0);
    total++;
    if ({s.busy, s.et} !== 2'b10) begin bad++; $display("FAIL to_early: got busy/et=%b want 10", {s.busy, s.et}); end
    idle(1);
    s = get_st(0);
    total++;
    if ({s.busy, s.et, s.done} !== 3'b010) begin bad++; $display("FAIL to_fire: got busy/et/done=%b want 010", {s.busy, s.et, s.done}); end
    #1;
    total++;
    if (wq_size(0) != 0) begin bad++; $display("FAIL to_nowr: got %0d writes want 0", wq_size(0)); end
    // byte arriving exactly in the expiry cycle is accepted
    pkt = '{8'hA5, 8'h00, 8'h01, 8'h12, 8'h34, 8'h26};
    bc.delete();
    for (int k = 0; k < 4; k++) begin send_byte(0, pkt[k], c); bc.push_back(c); end
    idle(100);
    for (int k = 4; k < 6; k++) begin send_byte(0, pkt[k], c); bc.push_back(c); end
    model(0);
    #1;
    s = get_st(0);
    total++;
    if ({s.busy, s.done, s.ec, s.el, s.et} !== {1'b0, exp_done, exp_ck, exp_len, 1'b0}) begin
      bad++; $display("FAIL to_edge_flags: got %b want %b", {s.busy, s.done, s.ec, s.el, s.et}, {1'b0, exp_done, exp_ck, exp_len, 1'b0});
    end
    total++;
    if (wq_size(0) != 1) begin
      bad++; $display("FAIL to_edge_nwr: got %0d want 1", wq_size(0));
    end else begin
      g = pop_wr(0); e = exp_q.pop_front();
      total++;
      if (g.addr !== e.addr || g.data !== e.data || g.cyc != e.cyc) begin
        bad++; $display("FAIL to_edge_wr: got a=%0h d=%h c=%0d want a=%0h d=%h c=%0d", g.addr, g.data, g.cyc, e.addr, e.data, e.cyc);
      end
    end
    while (wq_size(0) > 0) g = pop_wr(0);
  endtask

  task automatic test_reset_mid;
    int c;
    logic [7:0] b[5];
    wr_t g;
    for (int k = 0; k < 5; k++) b[k] = 8'($urandom);
    send_byte(2, 8'hA5, c);
    send_byte(2, 8'h00, c);
    send_byte(2, 8'h02, c);
    for (int k = 0; k < 5; k++) begin
      send_byte(2, b[k], c);
      if (k == 3) bc = '{c};
    end
    #1;
    total++;
    if (wq_size(2) != 1) begin
      bad++; $display("FAIL rm_pre_nwr: got %0d want 1", wq_size(2));
    end else begin
      g = pop_wr(2);
      total++;
      if (g.addr !== 32'h0 || g.data !== {b[0], b[1], b[2], b[3]} || g.cyc != bc[0]) begin
        bad++; $display("FAIL rm_pre_wr: got a=%0h d=%h c=%0d want a=0 d=%h c=%0d", g.addr, g.data, g.cyc, {b[0], b[1], b[2], b[3]}, bc[0]);
      end
    end
    total++;
    if (busy2 !== 1'b1) begin bad++; $display("FAIL rm_busy: got %b want 1", busy2); end
    #2 rst = 1'b1;
    #1;
    total++;
    if ({en2, wa2, din2, busy2, done2, ec2, el2, et2, wc2} !== '0) begin
      bad++; $display("FAIL rm_async: got %h want 0", {en2, wa2, din2, busy2, done2, ec2, el2, et2, wc2});
    end
    @(negedge clk);
    rst = 1'b0;
    send_byte(2, 8'h11, c);
    send_byte(2, 8'h22, c);
    send_byte(2, 8'h33, c);
    send_byte(2, 8'h44, c);
    idle(2);
    total++;
    if (wq_size(2) != 0) begin bad++; $display("FAIL rm_post_nwr: got %0d want 0", wq_size(2)); end
    total++;
    if ({busy2, done2, wc2} !== '0) begin bad++; $display("FAIL rm_post_st: got %h want 0", {busy2, done2, wc2}); end
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      rxd[k] = 1'b0;
      rxb[k] = 8'h00;
    end
    test_reset();
    test_directed();
    test_length();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
